bp_update_queue: RTL and testbench
==================================

# bp_update_queue

Frontend-to-execute bookkeeping queue for branch predictor training. At prediction time the frontend pushes one entry per predicted conditional branch, holding the global (gbp) and local (lbp) predictor outputs used for that branch. At resolution the execute stage pops the head entry in program order. The block then drives, one cycle later, the resolved update together with the stored gbp/lbp predictions in the format the choice predictor expects.

## Interface
- CVA6Cfg, config_pkg::cva6_cfg_empty: core config; uses VLEN, RVC, INSTR_PER_FETCH.
- bht_update_t, logic: struct with fields valid, pc[VLEN], taken.
- bht_prediction_t, logic: struct with fields valid, taken.
- DEPTH, 8: entry count; power of two, ≥2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  discard all entries.
- push_valid_i  in  1  record a predicted branch.
- push_ready_o  out  1  queue not full.
- push_pc_i  in  VLEN  branch PC.
- push_gbp_i  in  bht_prediction_t  gbp prediction used.
- push_lbp_i  in  bht_prediction_t  lbp prediction used.
- resolve_valid_i  in  1  oldest outstanding branch resolved.
- resolve_pc_i  in  VLEN  resolved PC.
- resolve_taken_i  in  1  actual direction.
- resolve_mispredict_i  in  1  frontend mispredicted this branch.
- bht_update_o  out  bht_update_t  training update.
- update_gbp_pred_o  out  bht_prediction_t[INSTR_PER_FETCH]  stored gbp prediction in slot.
- update_lbp_pred_o  out  bht_prediction_t[INSTR_PER_FETCH]  stored lbp prediction in slot.
- count_o  out  $clog2(DEPTH)+1  occupied entries.
- pc_mismatch_o  out  1  one-cycle pulse: head PC ≠ resolve_pc_i.
- orphan_o  out  1  one-cycle pulse: resolve while empty.

## Operation
- Storage: circular buffer with DEPTH entries {pc, gbp, lbp}, read pointer rd_ptr and write pointer wr_ptr of $clog2(DEPTH) bits, both wrapping modulo DEPTH, plus count register.
- push_ready_o = (count < DEPTH). It depends on registered count only and has no path from resolve_valid_i.
- Push accepted when push_valid_i && push_ready_o && !flush_i && !(resolve_valid_i && resolve_mispredict_i).
  - A push offered when not ready is dropped silently.
- Resolve when count>0: head popped.
  - bht_update_o <= {1, resolve_pc_i, resolve_taken_i}.
  - slot = resolve_pc_i[ROW_ADDR_BITS+OFFSET-1:OFFSET] if RVC, else 0. OFFSET = 1 if RVC, else 2. ROW_ADDR_BITS = $clog2(INSTR_PER_FETCH).
  - update_*_pred_o[slot] <= stored gbp/lbp. All other slots <= '0.
- PC mismatch when count>0 and head.pc ≠ resolve_pc_i:
  - The head is still popped and the update is still emitted.
  - Both slot predictions are forced to valid=0, which makes the chooser hold its counter.
  - pc_mismatch_o pulses.
- Resolve when count==0: no pop; bht_update_o.valid <= 0; orphan_o pulses.
- Mispredict: the head is processed as above, then every remaining entry is discarded (count <= 0, wr_ptr <= rd_ptr+1, rd_ptr <= rd_ptr+1). The same-cycle push is dropped.
- flush_i:
  - count <= 0, rd_ptr <= wr_ptr.
  - The same-cycle push is dropped.
  - A same-cycle resolve is still processed; its update is emitted.
- Simultaneous push and pop (no mispredict, not full): count unchanged, both pointers advance.
- When not full, a push and a pop in the same cycle are both accepted. When full, the push is blocked and count decrements.
- Arithmetic: pointer increments are modulo DEPTH. count never exceeds DEPTH or goes below 0.

## Timing
- Reset:
  - bht_update_o='0, update_gbp_pred_o='0, update_lbp_pred_o='0.
  - count_o=0, push_ready_o=1.
  - pc_mismatch_o=0, orphan_o=0.
  - Pointers 0.
- Resolve in cycle N: bht_update_o.valid, predictions and pulses are valid in cycle N+1 for exactly one cycle, unless another resolve occurs in N+1.
- Push in cycle N: the entry is visible to a resolve from cycle N+1. There is no same-cycle bypass, so a push and a resolve on an empty queue in the same cycle give orphan.
- count_o and push_ready_o update one cycle after the event.
- Reset mid-operation: all state clears immediately (asynchronous). Any pending update is lost.
- All outputs are registered.

## Test plan
- Reset: hold rst_ni=0 for 3 cycles with push_valid_i=1 → after release, count_o=0, push_ready_o=1, bht_update_o.valid=0, no pulses.
- In-order train (RVC, INSTR_PER_FETCH=2):
  - Push pc 0x80000000 {gbp v1 t1, lbp v1 t0}, then 0x8000000A {gbp v1 t0, lbp v1 t1}.
  - Resolve both, taken=1.
  - Cycle+1 of the first resolve: update pc 0x80000000, slot0 gbp t1 / lbp t0, slot1 '0.
  - Cycle+1 of the second resolve: data in slot1.
- Full: push 9 entries with DEPTH=8 → count_o=8, push_ready_o=0, 9th dropped. Then resolve and push together → count_o=7, push not taken.
- Mispredict: push 4, resolve head with mispredict=1 and push_valid_i=1 → update emitted, count_o=0 next cycle, next resolve gives orphan_o=1.
- Mismatch: push pc 0x80000010, resolve pc 0x80000014 → update pc 0x80000014, slot predictions valid=0, pc_mismatch_o=1 for one cycle, count_o=0.
- Flush + wrap: push and pop 12 entries so pointers wrap. Then push 3, assert flush_i with resolve_valid_i → update emitted, count_o=0, push_ready_o=1.

Source files
------------

// File: rtl/bp_update_queue_if.sv
// Bundle of the push (frontend), resolve (execute) and training-update signals
// of bp_update_queue.
//
// Prediction encoding: 2 bits {valid, taken}; bit 1 is valid and bit 0 is taken.
// Update encoding: {valid, pc[VLEN-1:0], taken}; the MSB is valid and bit 0 is taken.
//
// Handshake: a push transfers on a rising clock edge only when push_valid_i and
// push_ready_o are both high. push_ready_o comes from registered state only, so
// the frontend may hold push_valid_i high while it waits. resolve_valid_i has
// no ready: a resolve is always consumed in the cycle it is presented.
interface bp_update_queue_if #(
  parameter int unsigned VLEN            = 32,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned DEPTH           = 8
);
  logic                                  flush_i;
  logic                                  push_valid_i;
  logic                                  push_ready_o;
  logic [VLEN-1:0]                       push_pc_i;
  logic [1:0]                            push_gbp_i;
  logic [1:0]                            push_lbp_i;
  logic                                  resolve_valid_i;
  logic [VLEN-1:0]                       resolve_pc_i;
  logic                                  resolve_taken_i;
  logic                                  resolve_mispredict_i;
  logic [VLEN+1:0]                       bht_update_o;
  logic [INSTR_PER_FETCH-1:0][1:0]       update_gbp_pred_o;
  logic [INSTR_PER_FETCH-1:0][1:0]       update_lbp_pred_o;
  logic [$clog2(DEPTH):0]                count_o;
  logic                                  pc_mismatch_o;
  logic                                  orphan_o;

  modport slave (
    input  flush_i, push_valid_i, push_pc_i, push_gbp_i, push_lbp_i,
           resolve_valid_i, resolve_pc_i, resolve_taken_i, resolve_mispredict_i,
    output push_ready_o, bht_update_o, update_gbp_pred_o, update_lbp_pred_o,
           count_o, pc_mismatch_o, orphan_o
  );

  modport master (
    output flush_i, push_valid_i, push_pc_i, push_gbp_i, push_lbp_i,
           resolve_valid_i, resolve_pc_i, resolve_taken_i, resolve_mispredict_i,
    input  push_ready_o, bht_update_o, update_gbp_pred_o, update_lbp_pred_o,
           count_o, pc_mismatch_o, orphan_o
  );
endinterface

// File: rtl/bp_update_queue.sv
// In-order queue of the predictions used for each conditional branch. An entry
// is pushed at prediction time and popped at resolution. One cycle after the
// resolve, the queue emits the training update with the stored gbp/lbp
// predictions placed in the fetch slot of the branch.
module bp_update_queue #(
  parameter int unsigned VLEN            = 32,
  parameter bit          RVC             = 1'b1,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned DEPTH           = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  bp_update_queue_if.slave bus
);
  localparam int unsigned PW            = $clog2(DEPTH);
  localparam int unsigned CW            = PW + 1;
  localparam int unsigned OFFSET        = RVC ? 1 : 2;
  localparam int unsigned ROW_ADDR_BITS = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);

  logic [VLEN-1:0] pc_mem  [DEPTH];
  logic [1:0]      gbp_mem [DEPTH];
  logic [1:0]      lbp_mem [DEPTH];

  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;

  logic                    pop, mp_pop, kill_push, push_ready, push_acc, mismatch;
  logic [ROW_ADDR_BITS-1:0] slot;
  logic [VLEN+1:0]                 update_d;
  logic [INSTR_PER_FETCH-1:0][1:0] gbp_d, lbp_d;

  // Accept/pop decisions and the update that a resolve produces this cycle
  always_comb begin
    pop        = bus.resolve_valid_i && (count_q != '0);
    mp_pop     = pop && bus.resolve_mispredict_i;
    kill_push  = bus.flush_i || (bus.resolve_valid_i && bus.resolve_mispredict_i);
    push_ready = count_q < DEPTH_C;
    push_acc   = bus.push_valid_i && push_ready && !kill_push;
    mismatch   = pop && (pc_mem[rd_ptr_q] != bus.resolve_pc_i);
    slot       = '0;
    if (RVC && (INSTR_PER_FETCH > 1)) slot = bus.resolve_pc_i[OFFSET +: ROW_ADDR_BITS];
    update_d   = '0;
    gbp_d      = '0;
    lbp_d      = '0;
    if (pop) begin
      update_d    = {1'b1, bus.resolve_pc_i, bus.resolve_taken_i};
      // A mismatched head clears valid so the chooser holds its counter
      gbp_d[slot] = {gbp_mem[rd_ptr_q][1] & ~mismatch, gbp_mem[rd_ptr_q][0]};
      lbp_d[slot] = {lbp_mem[rd_ptr_q][1] & ~mismatch, lbp_mem[rd_ptr_q][0]};
    end
  end

  // Entry storage, written on accepted pushes only
  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      pc_mem[wr_ptr_q]  <= bus.push_pc_i;
      gbp_mem[wr_ptr_q] <= bus.push_gbp_i;
      lbp_mem[wr_ptr_q] <= bus.push_lbp_i;
    end
  end

  // Pointers and occupancy; flush wins, then mispredict discards the younger entries
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.flush_i) begin
      rd_ptr_q <= wr_ptr_q;
      count_q  <= '0;
    end else if (mp_pop) begin
      rd_ptr_q <= rd_ptr_q + PW'(1);
      wr_ptr_q <= rd_ptr_q + PW'(1);
      count_q  <= '0;
    end else begin
      if (pop)      rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_acc) wr_ptr_q <= wr_ptr_q + PW'(1);
      case ({push_acc, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Registered training outputs and one-cycle status pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.bht_update_o      <= '0;
      bus.update_gbp_pred_o <= '0;
      bus.update_lbp_pred_o <= '0;
      bus.pc_mismatch_o     <= 1'b0;
      bus.orphan_o          <= 1'b0;
    end else begin
      bus.bht_update_o      <= update_d;
      bus.update_gbp_pred_o <= gbp_d;
      bus.update_lbp_pred_o <= lbp_d;
      bus.pc_mismatch_o     <= mismatch;
      bus.orphan_o          <= bus.resolve_valid_i && (count_q == '0);
    end
  end

  // Occupancy-derived outputs come straight from the registered count
  always_comb begin
    bus.count_o      = count_q;
    bus.push_ready_o = push_ready;
  end
endmodule

// File: tb/tb_bp_update_queue.sv
// Bench for bp_update_queue: queue-based reference model, per-cycle compare
// process, directed scenarios with literal expectations, then random traffic.
module tb_bp_update_queue;
  localparam int VLEN = 32;
  localparam int IPF  = 2;
  localparam int DEPTH = 8;

  typedef struct {
    logic [VLEN-1:0] pc;
    logic [1:0]      gbp;
    logic [1:0]      lbp;
  } ent_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b1;

  bp_update_queue_if #(.VLEN(VLEN), .INSTR_PER_FETCH(IPF), .DEPTH(DEPTH)) bus ();

  bp_update_queue #(.VLEN(VLEN), .RVC(1'b1), .INSTR_PER_FETCH(IPF), .DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  ent_t                   mq[$];
  logic [VLEN+1:0]        exp_upd;
  logic [IPF-1:0][1:0]    exp_g, exp_l;
  logic                   exp_mm, exp_orph;
  int                     sz, slot;
  bit                     push_ok;
  ent_t                   ne;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      mq.delete();
      exp_upd = '0; exp_g = '0; exp_l = '0; exp_mm = 0; exp_orph = 0;
    end else begin
      sz = mq.size();
      exp_upd = '0; exp_g = '0; exp_l = '0; exp_mm = 0; exp_orph = 0;
      push_ok = bus.push_valid_i && (sz < DEPTH) && !bus.flush_i &&
                !(bus.resolve_valid_i && bus.resolve_mispredict_i);
      if (bus.resolve_valid_i) begin
        if (sz == 0) begin
          exp_orph = 1;
        end else begin
          slot = (bus.resolve_pc_i >> 1) % IPF;
          exp_upd = {1'b1, bus.resolve_pc_i, bus.resolve_taken_i};
          exp_mm = (mq[0].pc != bus.resolve_pc_i);
          exp_g[slot] = {mq[0].gbp[1] && !exp_mm, mq[0].gbp[0]};
          exp_l[slot] = {mq[0].lbp[1] && !exp_mm, mq[0].lbp[0]};
          void'(mq.pop_front());
          if (bus.resolve_mispredict_i) mq.delete();
        end
      end
      if (bus.flush_i) mq.delete();
      if (push_ok) begin
        ne.pc = bus.push_pc_i; ne.gbp = bus.push_gbp_i; ne.lbp = bus.push_lbp_i;
        mq.push_back(ne);
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_ni && chk_en) begin
      chk("count",    64'(bus.count_o), 64'(mq.size()));
      chk("ready",    64'(bus.push_ready_o), 64'(mq.size() < DEPTH));
      chk("update",   64'(bus.bht_update_o), 64'(exp_upd));
      chk("gbp_pred", 64'(bus.update_gbp_pred_o), 64'(exp_g));
      chk("lbp_pred", 64'(bus.update_lbp_pred_o), 64'(exp_l));
      chk("mismatch", 64'(bus.pc_mismatch_o), 64'(exp_mm));
      chk("orphan",   64'(bus.orphan_o), 64'(exp_orph));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit pv, input logic [VLEN-1:0] pc, input logic [1:0] g, input logic [1:0] l,
                       input bit rv, input logic [VLEN-1:0] rpc, input bit rt, input bit mp, input bit fl);
    bus.push_valid_i = pv; bus.push_pc_i = pc; bus.push_gbp_i = g; bus.push_lbp_i = l;
    bus.resolve_valid_i = rv; bus.resolve_pc_i = rpc; bus.resolve_taken_i = rt;
    bus.resolve_mispredict_i = mp; bus.flush_i = fl;
    @(negedge clk);
  endtask

  task automatic push(input logic [VLEN-1:0] pc, input logic [1:0] g, input logic [1:0] l);
    drive(1, pc, g, l, 0, '0, 0, 0, 0);
  endtask

  task automatic resolve(input logic [VLEN-1:0] rpc, input bit rt, input bit mp);
    drive(0, '0, 2'b00, 2'b00, 1, rpc, rt, mp, 0);
  endtask

  task automatic idle();
    drive(0, '0, 2'b00, 2'b00, 0, '0, 0, 0, 0);
  endtask

  function automatic logic [VLEN-1:0] head_pc();
    return (mq.size() != 0) ? mq[0].pc : '0;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bus.push_valid_i = 1; bus.push_pc_i = 32'h80000000; bus.push_gbp_i = 2'b11; bus.push_lbp_i = 2'b11;
    bus.resolve_valid_i = 0; bus.resolve_pc_i = '0; bus.resolve_taken_i = 0;
    bus.resolve_mispredict_i = 0; bus.flush_i = 0;

    // Reset held for 3 cycles with a push offered
    repeat (3) @(negedge clk);
    bus.push_valid_i = 0;
    rst_ni = 1'b1;
    chk("rst_count",  64'(bus.count_o), 64'd0);
    chk("rst_ready",  64'(bus.push_ready_o), 64'd1);
    chk("rst_upd",    64'(bus.bht_update_o), 64'd0);
    chk("rst_pulses", 64'({bus.pc_mismatch_o, bus.orphan_o}), 64'd0);
    idle();

    // In-order train across two fetch slots
    push(32'h80000000, 2'b11, 2'b10);
    push(32'h8000000A, 2'b10, 2'b11);
    resolve(32'h80000000, 1, 0);
    chk("train0_upd", 64'(bus.bht_update_o), 64'({1'b1, 32'h80000000, 1'b1}));
    chk("train0_gbp", 64'(bus.update_gbp_pred_o), 64'h3);
    chk("train0_lbp", 64'(bus.update_lbp_pred_o), 64'h2);
    resolve(32'h8000000A, 1, 0);
    chk("train1_upd", 64'(bus.bht_update_o), 64'({1'b1, 32'h8000000A, 1'b1}));
    chk("train1_gbp", 64'(bus.update_gbp_pred_o), 64'h8);
    chk("train1_lbp", 64'(bus.update_lbp_pred_o), 64'hC);
    idle();
    chk("train_single_cycle", 64'(bus.bht_update_o), 64'd0);

    // Fill past capacity, then simultaneous push and pop while full
    for (int i = 0; i < 9; i++) push(32'h80001000 + 32'(i * 4), 2'(i), 2'(i + 1));
    chk("full_count", 64'(bus.count_o), 64'd8);
    chk("full_ready", 64'(bus.push_ready_o), 64'd0);
    drive(1, 32'h80002000, 2'b11, 2'b11, 1, head_pc(), 1, 0, 0);
    chk("full_pushpop_count", 64'(bus.count_o), 64'd7);
    chk("full_pop_pc", 64'(bus.bht_update_o), 64'({1'b1, 32'h80001000, 1'b1}));
    for (int i = 0; i < 7; i++) resolve(head_pc(), 0, 0);
    chk("drained", 64'(bus.count_o), 64'd0);

    // Mispredict discards younger entries and the same-cycle push
    for (int i = 0; i < 4; i++) push(32'h80003000 + 32'(i * 2), 2'b11, 2'b01);
    drive(1, 32'h80004000, 2'b11, 2'b11, 1, head_pc(), 0, 1, 0);
    chk("mp_upd_valid", 64'(bus.bht_update_o[VLEN+1]), 64'd1);
    chk("mp_count", 64'(bus.count_o), 64'd0);
    resolve(32'h80003002, 1, 0);
    chk("mp_orphan", 64'(bus.orphan_o), 64'd1);
    chk("mp_orphan_upd", 64'(bus.bht_update_o), 64'd0);

    // PC mismatch: update emitted with invalidated predictions
    push(32'h80000010, 2'b11, 2'b11);
    resolve(32'h80000014, 1, 0);
    chk("mm_upd", 64'(bus.bht_update_o), 64'({1'b1, 32'h80000014, 1'b1}));
    chk("mm_gbp", 64'(bus.update_gbp_pred_o), 64'h1);
    chk("mm_lbp", 64'(bus.update_lbp_pred_o), 64'h1);
    chk("mm_pulse", 64'(bus.pc_mismatch_o), 64'd1);
    chk("mm_count", 64'(bus.count_o), 64'd0);
    idle();
    chk("mm_pulse_end", 64'(bus.pc_mismatch_o), 64'd0);

    // Wrap the pointers, then flush with a same-cycle resolve
    push(32'h80005000, 2'b10, 2'b10);
    for (int i = 1; i <= 12; i++)
      drive(1, 32'h80005000 + 32'(i * 2), 2'(i), 2'(i + 2), 1, head_pc(), 1, 0, 0);
    resolve(head_pc(), 0, 0);
    for (int i = 0; i < 3; i++) push(32'h80006000 + 32'(i * 4), 2'b11, 2'b10);
    drive(1, 32'h80007000, 2'b11, 2'b11, 1, head_pc(), 1, 0, 1);
    chk("fl_upd", 64'(bus.bht_update_o), 64'({1'b1, 32'h80006000, 1'b1}));
    chk("fl_count", 64'(bus.count_o), 64'd0);
    chk("fl_ready", 64'(bus.push_ready_o), 64'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      automatic bit pv = ($urandom_range(0, 99) < 60);
      automatic bit rv = ($urandom_range(0, 99) < 40);
      automatic bit mp = ($urandom_range(0, 99) < 8);
      automatic bit fl = ($urandom_range(0, 99) < 3);
      automatic logic [VLEN-1:0] rpc = ($urandom_range(0, 99) < 85) ? head_pc() : ($urandom() & ~32'h1);
      drive(pv, $urandom() & ~32'h1, 2'($urandom()), 2'($urandom()), rv, rpc, 1'($urandom()), mp, fl);
    end

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) push(32'h80008000 + 32'(i * 2), 2'b11, 2'b11);
    drive(0, '0, 2'b00, 2'b00, 1, head_pc(), 1, 0, 0);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_count",  64'(bus.count_o), 64'd0);
    chk("arst_upd",    64'(bus.bht_update_o), 64'd0);
    chk("arst_ready",  64'(bus.push_ready_o), 64'd1);
    bus.resolve_valid_i = 0;
    @(negedge clk);
    rst_ni = 1'b1;
    idle();
    resolve(32'h80008000, 1, 0);
    chk("arst_orphan", 64'(bus.orphan_o), 64'd1);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
